// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the ALU command sequencer: op encodings,
// FSM states and the packed command layout.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam int unsigned A_LSB   = 0;
    localparam int unsigned B_LSB   = 3;
    localparam int unsigned SEL_LSB = 6;
    localparam int unsigned CMD_W   = 8;
    localparam int unsigned RES_W   = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_CAPTURE
    } state_t;

    // Field order matches {sel[7:6], B[5:3], A[2:0]}.
    typedef struct packed {
        logic [1:0] sel;
        logic [2:0] b;
        logic [2:0] a;
    } cmd_t;

endpackage

// File: rtl/alu_op_sequencer_fifo.sv
// Response FIFO with a registered head: rdata/empty are flops, loaded with
// the next head value so a push into an empty FIFO is visible one edge later.
module alu_rsp_fifo #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic [AW:0]      count_next;
    logic [AW:0]      remaining;
    logic [WIDTH-1:0] head_next;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + ONE;
        end else if (!do_push && do_pop) begin
            count_next = count - ONE;
        end
        rd_next   = do_pop ? rd_ptr + AW'(1) : rd_ptr;
        remaining = do_pop ? count - ONE : count;
        // With no older entry left, the head comes straight from the write port.
        head_next = rdata;
        if (remaining == '0) begin
            if (do_push) begin
                head_next = wdata;
            end
        end else begin
            head_next = mem[rd_next];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdata  <= '0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_next;
            count  <= count_next;
            rdata  <= head_next;
            empty  <= (count_next == '0);
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-side sequencer for the ALU core: latches one command, holds the
// operands for ALU_LAT cycles, then captures the result into the response FIFO.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CMD_W-1:0]    cmd_data,
    output logic [2:0]          alu_a,
    output logic [2:0]          alu_b,
    output logic [1:0]          alu_sel,
    input  logic [RES_W-1:0]    alu_result,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [RES_W-1:0]    rsp_data,
    output logic                busy
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    state_t          state;
    state_t          state_next;
    cmd_t            cmd;
    logic [CW-1:0]   hold_cnt;
    logic            load_ops;
    logic            push;
    logic            pending;
    logic            fifo_full;
    logic            fifo_empty;
    logic [AW:0]     fifo_count;
    logic [AW+1:0]   occupancy;

    assign cmd       = cmd_t'(cmd_data);
    assign busy      = (state != S_IDLE);
    assign pending   = (state != S_IDLE);
    // In-flight command counts against capacity so CAPTURE always has a free slot.
    assign occupancy = {1'b0, fifo_count} + (AW+2)'(pending);
    assign rsp_valid = ~fifo_empty;

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        load_ops   = 1'b0;
        push       = 1'b0;
        unique case (state)
            S_IDLE: begin
                cmd_ready = rst_n & ~fifo_full & (occupancy < (AW+2)'(DEPTH));
                if (cmd_valid && cmd_ready) begin
                    load_ops   = 1'b1;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_cnt == '0) begin
                    state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                push       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= '0;
        end else begin
            state <= state_next;
            if (load_ops) begin
                alu_a    <= cmd.a;
                alu_b    <= cmd.b;
                alu_sel  <= cmd.sel;
                hold_cnt <= CW'(ALU_LAT - 1);
            end else if (state == S_HOLD && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - CW'(1);
            end
        end
    end

    alu_rsp_fifo #(
        .WIDTH (RES_W),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (alu_result),
        .pop   (rsp_ready),
        .rdata (rsp_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed protocol steps plus a randomized run
// scored against an in-order queue of expected ALU results.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic [2:0] alu_a;
    logic [2:0] alu_b;
    logic [1:0] alu_sel;
    logic [5:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [5:0] rsp_data;
    logic       busy;

    int tests  = 0;
    int failed = 0;

    logic [7:0] send_q[$];
    logic [5:0] exp_q[$];
    int accepts;
    int pops;
    int last_accept_pops;

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .ALU_LAT (1),
        .DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    function automatic logic [5:0] alu_ref(input logic [2:0] a, input logic [2:0] b,
                                           input logic [1:0] sel);
        int r;
        case (sel)
            OP_ADD:  r = int'(a) + int'(b);
            OP_SUB:  r = int'(a) - int'(b) + 64;
            OP_AND:  r = int'(a & b);
            default: r = int'(a | b);
        endcase
        return 6'(r % 64);
    endfunction

    function automatic logic [5:0] cmd_result(input logic [7:0] c);
        return alu_ref(c[2:0], c[5:3], c[7:6]);
    endfunction

    // Stand-in for the combinational ALU core beside the sequencer.
    always_comb alu_result = alu_ref(alu_a, alu_b, alu_sel);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of scoreboarded traffic; decisions are made at the falling edge.
    task automatic cycle(input bit rdy);
        @(negedge clk);
        if (exp_q.size() >= DEPTH) check("full_stall", 32'(cmd_ready), 0);
        if (send_q.size() > 0) begin
            cmd_valid = 1'b1;
            cmd_data  = send_q[0];
            if (cmd_ready) begin
                exp_q.push_back(cmd_result(send_q[0]));
                void'(send_q.pop_front());
                accepts++;
                last_accept_pops = pops;
            end
        end else begin
            cmd_valid = 1'b0;
        end
        rsp_ready = rdy;
        if (rsp_valid && rdy) begin
            if (exp_q.size() == 0) begin
                check("spurious_rsp", 32'(exp_q.size()), 1);
            end else begin
                check("rsp_order", 32'(rsp_data), 32'(exp_q.pop_front()));
                pops++;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int stale;

        // Reset with random inputs
        rst_n = 1'b0;
        repeat (3) begin
            cmd_valid = 1'($urandom);
            cmd_data  = 8'($urandom);
            rsp_ready = 1'($urandom);
            @(negedge clk);
        end
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_alu_ops", 32'({alu_sel, alu_b, alu_a}), 0);
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        rst_n     = 1'b1;
        #1;
        check("rel_cmd_ready", 32'(cmd_ready), 1);

        // Single ADD: timing of operands and response
        cmd_valid = 1'b1;
        cmd_data  = 8'b00_011_010;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("add_busy_hold", 32'(busy), 1);
        check("add_alu_a", 32'(alu_a), 2);
        check("add_alu_b", 32'(alu_b), 3);
        check("add_alu_sel", 32'(alu_sel), 0);
        check("add_ready_hold", 32'(cmd_ready), 0);
        check("add_no_rsp_1", 32'(rsp_valid), 0);
        @(negedge clk);
        check("add_alu_a_cap", 32'(alu_a), 2);
        check("add_no_rsp_2", 32'(rsp_valid), 0);
        @(negedge clk);
        check("add_rsp_valid", 32'(rsp_valid), 1);
        check("add_rsp_data", 32'(rsp_data), 5);
        check("add_busy_idle", 32'(busy), 0);
        check("add_alu_a_keep", 32'(alu_a), 2);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("add_popped", 32'(rsp_valid), 0);
        rsp_ready = 1'b0;

        // SUB wrap and accept-to-valid latency
        cmd_valid = 1'b1;
        cmd_data  = 8'b01_100_001;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("sub_latency", 32'(n), 3);
        check("sub_wrap_data", 32'(rsp_data), 61);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Back-pressure: five commands into a four-entry FIFO
        accepts = 0;
        pops    = 0;
        for (int i = 0; i < 5; i++) send_q.push_back(8'($urandom));
        repeat (25) cycle(1'b0);
        check("bp_accepted", 32'(accepts), 4);
        check("bp_cmd_ready", 32'(cmd_ready), 0);
        check("bp_rsp_valid", 32'(rsp_valid), 1);
        pops = 0;
        n = 0;
        while ((send_q.size() > 0 || exp_q.size() > 0) && n < 60) begin
            cycle(1'b1);
            n++;
        end
        check("bp_drained", 32'(exp_q.size() + send_q.size()), 0);
        check("bp_fifth_after_pop", 32'(last_accept_pops), 1);
        repeat (2) cycle(1'b0);

        // Simultaneous push and pop with one entry held
        cmd_valid = 1'b1;
        cmd_data  = 8'b11_101_010;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pp_first_data", 32'(rsp_data), 7);
        check("pp_ready_one", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_data  = 8'b10_110_011;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("pp_capture_busy", 32'(busy), 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("pp_valid_kept", 32'(rsp_valid), 1);
        check("pp_second_data", 32'(rsp_data), 2);
        @(negedge clk);
        check("pp_count_one", 32'(rsp_valid), 0);
        rsp_ready = 1'b0;

        // Reset in the middle of an operation
        cmd_valid = 1'b1;
        cmd_data  = 8'b00_111_111;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = 8'b01_001_110;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("mr_busy_before", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_busy", 32'(busy), 0);
        check("mr_rsp_valid", 32'(rsp_valid), 0);
        check("mr_cmd_ready", 32'(cmd_ready), 0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) stale++;
        end
        check("mr_no_stale", 32'(stale), 0);
        rsp_ready = 1'b0;

        // Randomized traffic against the ordered scoreboard
        for (int i = 0; i < 40; i++) send_q.push_back(8'($urandom));
        n = 0;
        while ((send_q.size() > 0 || exp_q.size() > 0) && n < 2000) begin
            cycle(1'($urandom_range(0, 1)));
            n++;
        end
        check("rand_drained", 32'(exp_q.size() + send_q.size()), 0);
        repeat (3) cycle(1'b0);
        check("rand_end_empty", 32'(rsp_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
